// File: rtl/clock_pkg.sv
// Shared constants and types for the clock display path: active-low segment
// patterns, digit geometry and the snapshot record captured once per frame.
package clock_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Cathode patterns are {g,f,e,d,c,b,a}, a zero lights the segment.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef logic [1:0] slot_t;

    typedef struct packed {
        logic [1:0] hour_tens;
        logic [3:0] hour_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
    } time_snap_t;

    function automatic logic [3:0] anode_for_slot(input slot_t slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a
// dash so a corrupted digit is visible rather than silently wrong.
module bcd_to_seg
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for the 4-digit common-anode display with per-frame
// snapshot, anti-ghost blanking and hour-tens suppression. Define COLON_BLINK_EN to blink the colon.
module seven_seg_scanner
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 2_000,
    parameter int BLINK_DIV    = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_ones,
    input  logic [1:0] hour_tens,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // A zero-length blank would let two anodes overlap across a slot boundary.
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be in 1..SCAN_DIV-1");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("BLINK_DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt;
    slot_t            slot;
    time_snap_t       snap;
    logic             cnt_wrap;
    logic             drive_phase;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_next;
    logic             colon_dp;

    assign cnt_wrap    = (cnt == CNT_W'(SCAN_DIV - 1));
    assign drive_phase = (cnt >= CNT_W'(BLANK_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt_wrap) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Capture on the last cycle of slot 3 so every frame shows one consistent time.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (cnt_wrap && slot == 2'd3) begin
            snap <= {hour_tens, hour_ones, min_tens, min_ones};
        end
    end

    always_comb begin
        cur_digit = snap.min_ones;
        case (slot)
            2'd0: cur_digit = snap.min_ones;
            2'd1: cur_digit = snap.min_tens;
            2'd2: cur_digit = snap.hour_ones;
            2'd3: cur_digit = {2'b00, snap.hour_tens};
            default: cur_digit = snap.min_ones;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    assign seg_next = (slot == 2'd3 && snap.hour_tens == 2'd0) ? SEG_OFF : dec_seg;

`ifdef COLON_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               colon_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            colon_on  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            colon_on  <= ~colon_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign colon_dp = ~colon_on;
`else
    assign colon_dp = 1'b0;
`endif

    // Registered outputs: every pin reflects the previous cycle's slot and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (drive_phase) begin
            an  <= anode_for_slot(slot);
            seg <= seg_next;
            dp  <= (slot == 2'd2) ? colon_dp : 1'b1;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a behavioural model pushes expected
// pin values as stimulus is driven, and each is popped after the clock edge.
module tb_seven_seg_scanner;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_DIV    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min_ones, min_tens, hour_ones;
    logic [1:0] hour_tens;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .hour_ones (hour_ones),
        .hour_tens (hour_tens),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } pins_t;

    pins_t exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    logic [6:0] ref_seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    int         m_cnt, m_slot, m_blink;
    logic       m_colon;
    logic [3:0] m_snap [4];

    logic [6:0] seen_seg   [4];
    int         drive_cnt  [4];
    int         dp_low_cnt;
    int         dp_stray;

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic clear_frame_stats();
        for (int i = 0; i < 4; i++) begin
            seen_seg[i]  = 7'bx;
            drive_cnt[i] = 0;
        end
        dp_low_cnt = 0;
        dp_stray   = 0;
    endtask

    // Model of one clock edge from the current model state and inputs.
    function automatic pins_t model_pins(input logic r);
        pins_t p;
        p = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
        if (!r && m_cnt >= BLANK_CYCLES) begin
            p.an  = ~(4'b0001 << m_slot);
            p.seg = (m_slot == 3 && m_snap[3] == 4'd0) ? 7'b1111111 : ref_seg[m_snap[m_slot]];
`ifdef COLON_BLINK_EN
            p.dp  = (m_slot == 2) ? ~m_colon : 1'b1;
`else
            p.dp  = (m_slot == 2) ? 1'b0 : 1'b1;
`endif
        end
        return p;
    endfunction

    task automatic model_advance(input logic r);
        if (r) begin
            m_cnt = 0; m_slot = 0; m_blink = 0; m_colon = 1'b1;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
        end else begin
            if (m_cnt == SCAN_DIV - 1) begin
                if (m_slot == 3) begin
                    m_snap[0] = min_ones;
                    m_snap[1] = min_tens;
                    m_snap[2] = hour_ones;
                    m_snap[3] = {2'b00, hour_tens};
                end
                m_cnt  = 0;
                m_slot = (m_slot + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (m_blink == BLINK_DIV - 1) begin
                m_blink = 0;
                m_colon = ~m_colon;
            end else begin
                m_blink++;
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [1:0] ht, input logic [3:0] ho,
                                  input logic [3:0] mt, input logic [3:0] mo, input int cycles);
        pins_t got, want;
        for (int c = 0; c < cycles; c++) begin
            reset = r; hour_tens = ht; hour_ones = ho; min_tens = mt; min_ones = mo;
            exp_q.push_back(model_pins(r));
            model_advance(r);
            @(posedge clk);
            #1;
            got  = '{an: an, seg: seg, dp: dp};
            want = exp_q.pop_front();
            check_output("an",  {12'd0, got.an},  {12'd0, want.an});
            check_output("seg", {9'd0, got.seg},  {9'd0, want.seg});
            check_output("dp",  {15'd0, got.dp},  {15'd0, want.dp});
            check_output("one_anode", {15'd0, ($countones(~an) <= 1)}, 16'd1);
            for (int i = 0; i < 4; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    seen_seg[i] = seg;
                    drive_cnt[i]++;
                    if (i == 2 && dp == 1'b0) dp_low_cnt++;
                end
            end
            if (dp == 1'b0 && an != 4'b1011) dp_stray++;
        end
    endtask

    initial begin
        clear_frame_stats();
        m_cnt = 0; m_slot = 0; m_blink = 0; m_colon = 1'b1;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;

        apply_stimulus(1'b1, 2'd1, 4'd2, 4'd5, 4'd9, 3);
        check_output("reset_an",  {12'd0, an},  16'h000f);
        check_output("reset_seg", {9'd0, seg},  16'h007f);
        check_output("reset_dp",  {15'd0, dp},  16'h0001);

        // 12:59 on the inputs; frame 1 still shows the zero snapshot.
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 3);
        check_output("first_drive_an",  {12'd0, an}, {12'd0, 4'b1110});
        check_output("first_drive_seg", {9'd0, seg}, {9'd0, 7'b1000000});
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 29);

        clear_frame_stats();
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 32);
        check_output("f12_d0", {9'd0, seen_seg[0]}, {9'd0, 7'b0010000});
        check_output("f12_d1", {9'd0, seen_seg[1]}, {9'd0, 7'b0010010});
        check_output("f12_d2", {9'd0, seen_seg[2]}, {9'd0, 7'b0100100});
        check_output("f12_d3", {9'd0, seen_seg[3]}, {9'd0, 7'b1111001});
        for (int i = 0; i < 4; i++) check_output("drive_cycles", 16'(drive_cnt[i]), 16'd6);
        check_output("dp_stray", 16'(dp_stray), 16'd0);
`ifndef COLON_BLINK_EN
        check_output("dp_steady", 16'(dp_low_cnt), 16'd6);
`endif

        // Inputs switch to 1:00 in the middle of slot 1; this frame must stay 12:59.
        clear_frame_stats();
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 12);
        apply_stimulus(1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 20);
        check_output("tear_d1", {9'd0, seen_seg[1]}, {9'd0, 7'b0010010});
        check_output("tear_d2", {9'd0, seen_seg[2]}, {9'd0, 7'b0100100});
        check_output("tear_d3", {9'd0, seen_seg[3]}, {9'd0, 7'b1111001});

        clear_frame_stats();
        apply_stimulus(1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 32);
        check_output("f100_d0", {9'd0, seen_seg[0]}, {9'd0, 7'b1000000});
        check_output("f100_d1", {9'd0, seen_seg[1]}, {9'd0, 7'b1000000});
        check_output("f100_d2", {9'd0, seen_seg[2]}, {9'd0, 7'b1111001});
        check_output("f100_d3", {9'd0, seen_seg[3]}, {9'd0, 7'b1111111});

        // 09:41: hour tens suppressed but its anode still driven.
        apply_stimulus(1'b0, 2'd0, 4'd9, 4'd4, 4'd1, 32);
        clear_frame_stats();
        apply_stimulus(1'b0, 2'd0, 4'd9, 4'd4, 4'd1, 32);
        check_output("f941_d3_drive", 16'(drive_cnt[3]), 16'd6);
        check_output("f941_d3", {9'd0, seen_seg[3]}, {9'd0, 7'b1111111});
        check_output("f941_d2", {9'd0, seen_seg[2]}, {9'd0, 7'b0010000});
        check_output("f941_d0", {9'd0, seen_seg[0]}, {9'd0, 7'b1111001});

        // Invalid minute ones shows a dash without disturbing the other digits.
        apply_stimulus(1'b0, 2'd0, 4'd9, 4'd4, 4'hC, 32);
        clear_frame_stats();
        apply_stimulus(1'b0, 2'd0, 4'd9, 4'd4, 4'hC, 32);
        check_output("dash_d0", {9'd0, seen_seg[0]}, {9'd0, 7'b0111111});
        check_output("dash_d1", {9'd0, seen_seg[1]}, {9'd0, 7'b0011001});
        check_output("dash_d2", {9'd0, seen_seg[2]}, {9'd0, 7'b0010000});

        // Reset in the middle of slot 2 drive.
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 20);
        check_output("pre_rst_an", {12'd0, an}, {12'd0, 4'b1011});
        apply_stimulus(1'b1, 2'd1, 4'd2, 4'd5, 4'd9, 1);
        check_output("mid_rst_an", {12'd0, an}, 16'h000f);
        check_output("mid_rst_dp", {15'd0, dp}, 16'h0001);
        clear_frame_stats();
        apply_stimulus(1'b0, 2'd1, 4'd2, 4'd5, 4'd9, 32);
        check_output("post_rst_d0", {9'd0, seen_seg[0]}, {9'd0, 7'b1000000});
        check_output("post_rst_d3", {9'd0, seen_seg[3]}, {9'd0, 7'b1111111});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
